// File: rtl/prio_arbiter.sv
// Eight-requester arbiter: fixed or round-robin winner selection, registered one-hot
// grant held until completion, withdrawal or hold-time timeout, then one release cycle.
module prio_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req_in,
  input  logic       rr_mode,
  input  logic       done_in,
  output logic [7:0] gnt_op,
  output logic [2:0] gnt_id_op,
  output logic       busy_op,
  output logic       timeout_op
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_CNT = 8'(HOLD_MAX);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] last_id;
  logic [2:0] fixed_id;
  logic [2:0] rr_id;
  logic [2:0] rr_idx;
  logic [2:0] win_id;
  logic       grantee_req;
  logic       release_now;
  logic       hit_timeout;

  // Fixed order: the highest set bit wins because later iterations overwrite.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fixed_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (req_in[i]) fixed_id = 3'(i);
    end
  end

  // Round-robin order: last_id-1, last_id-2, ... wrapping, last_id itself last.
  // Iterating from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    rr_id  = '0;
    rr_idx = '0;
    for (int i = 8; i >= 1; i--) begin
      rr_idx = last_id - 3'(i);
      if (req_in[rr_idx]) rr_id = rr_idx;
    end
  end

  assign win_id      = rr_mode ? rr_id : fixed_id;
  assign grantee_req = req_in[gnt_id_op];
  assign release_now = done_in || !grantee_req || (cnt == HOLD_CNT);
  // Timeout only counts when neither completion nor withdrawal ended the grant.
  assign hit_timeout = !done_in && grantee_req && (cnt == HOLD_CNT);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_op     <= '0;
      gnt_id_op  <= '0;
      busy_op    <= 1'b0;
      timeout_op <= 1'b0;
      cnt        <= '0;
      last_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (req_in != 8'd0)) begin
            gnt_op    <= 8'd1 << win_id;
            gnt_id_op <= win_id;
            cnt       <= 8'd1;
            busy_op   <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            timeout_op <= hit_timeout;
            last_id    <= gnt_id_op;
            gnt_op     <= '0;
            gnt_id_op  <= '0;
            cnt        <= '0;
            state      <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          timeout_op <= 1'b0;
          busy_op    <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          gnt_op     <= '0;
          gnt_id_op  <= '0;
          busy_op    <= 1'b0;
          timeout_op <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (HOLD_MAX=4): each step queues the expected
// outputs, advances one clock, then pops and compares the registered outputs.
module tb_prio_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req_in;
  logic       rr_mode;
  logic       done_in;
  logic [7:0] gnt_op;
  logic [2:0] gnt_id_op;
  logic       busy_op;
  logic       timeout_op;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];

  prio_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_in    (req_in),
    .rr_mode   (rr_mode),
    .done_in   (done_in),
    .gnt_op    (gnt_op),
    .gnt_id_op (gnt_id_op),
    .busy_op   (busy_op),
    .timeout_op(timeout_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // id < 0 means no grant is expected after this edge.
  task automatic cyc(input string tag, input int id, input logic busy, input logic to);
    exp_t       e;
    exp_t       got;
    logic [7:0] one;
    one    = 8'd1;
    e.tag  = tag;
    e.busy = busy;
    e.to   = to;
    if (id < 0) begin
      e.gnt = 8'd0;
      e.id  = 3'd0;
    end else begin
      e.gnt = one << id;
      e.id  = 3'(id);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    compared++;
    assert (gnt_op === got.gnt) else begin
      mismatched++;
      $error("FAIL %s gnt_op observed %b expected %b", got.tag, gnt_op, got.gnt);
    end
    compared++;
    assert (gnt_id_op === got.id) else begin
      mismatched++;
      $error("FAIL %s gnt_id_op observed %0d expected %0d", got.tag, gnt_id_op, got.id);
    end
    compared++;
    assert (busy_op === got.busy) else begin
      mismatched++;
      $error("FAIL %s busy_op observed %b expected %b", got.tag, busy_op, got.busy);
    end
    compared++;
    assert (timeout_op === got.to) else begin
      mismatched++;
      $error("FAIL %s timeout_op observed %b expected %b", got.tag, timeout_op, got.to);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every requester active.
    rst = 1'b1; en = 1'b1; req_in = 8'hFF; rr_mode = 1'b0; done_in = 1'b0;
    cyc("rst_0", -1, 1'b0, 1'b0);
    cyc("rst_1", -1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("first_grant_7", 7, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("first_release", -1, 1'b1, 1'b0);
    done_in = 1'b0; req_in = 8'h00;
    cyc("first_idle", -1, 1'b0, 1'b0);

    // Fixed priority.
    req_in = 8'b0010_0110;
    cyc("fix_grant_5", 5, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("fix_release", -1, 1'b1, 1'b0);
    done_in = 1'b0;
    cyc("fix_idle", -1, 1'b0, 1'b0);
    cyc("fix_regrant_5", 5, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("fix_release2", -1, 1'b1, 1'b0);
    done_in = 1'b0; req_in = 8'h00;
    cyc("fix_idle2", -1, 1'b0, 1'b0);

    // Round-robin from a cleared last_id: 7,0,7,0.
    rst = 1'b1; rr_mode = 1'b1; req_in = 8'b1000_0001;
    cyc("rr_rst", -1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("rr_grant_%0d", k), (k % 2 == 0) ? 7 : 0, 1'b1, 1'b0);
      done_in = 1'b1;
      cyc($sformatf("rr_release_%0d", k), -1, 1'b1, 1'b0);
      done_in = 1'b0;
      if (k == 3) req_in = 8'h00;
      cyc($sformatf("rr_idle_%0d", k), -1, 1'b0, 1'b0);
    end

    // Timeout after exactly HOLD_MAX grant cycles, then re-grant.
    rr_mode = 1'b0; req_in = 8'b0000_1000;
    for (int k = 1; k <= 4; k++) cyc($sformatf("to_hold_%0d", k), 3, 1'b1, 1'b0);
    cyc("to_pulse", -1, 1'b1, 1'b1);
    cyc("to_idle", -1, 1'b0, 1'b0);
    cyc("to_regrant_3", 3, 1'b1, 1'b0);
    req_in = 8'h00;
    cyc("to_withdraw", -1, 1'b1, 1'b0);
    cyc("to_idle2", -1, 1'b0, 1'b0);

    // done_in in the final hold cycle wins over timeout.
    req_in = 8'b0000_1000;
    for (int k = 1; k <= 4; k++) cyc($sformatf("dw_hold_%0d", k), 3, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("dw_release_no_to", -1, 1'b1, 1'b0);
    done_in = 1'b0; req_in = 8'h00;
    cyc("dw_idle", -1, 1'b0, 1'b0);

    // Enable gating.
    en = 1'b0; req_in = 8'hFF;
    cyc("en0_no_grant_a", -1, 1'b0, 1'b0);
    cyc("en0_no_grant_b", -1, 1'b0, 1'b0);
    en = 1'b1; req_in = 8'b0100_0000;
    cyc("en_grant_6", 6, 1'b1, 1'b0);
    en = 1'b0;
    cyc("en_drop_holds_6", 6, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("en_release", -1, 1'b1, 1'b0);
    done_in = 1'b0;
    for (int k = 0; k < 3; k++) cyc($sformatf("en0_blocked_%0d", k), -1, 1'b0, 1'b0);

    // Withdrawal.
    en = 1'b1;
    cyc("wd_grant_6", 6, 1'b1, 1'b0);
    cyc("wd_hold_6", 6, 1'b1, 1'b0);
    req_in = 8'h00;
    cyc("wd_release", -1, 1'b1, 1'b0);
    cyc("wd_idle", -1, 1'b0, 1'b0);

    // Reset in the third grant cycle; last_id must clear so 7 wins in rr mode.
    req_in = 8'b0100_0000;
    cyc("mr_grant_1", 6, 1'b1, 1'b0);
    cyc("mr_grant_2", 6, 1'b1, 1'b0);
    cyc("mr_grant_3", 6, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("mr_reset", -1, 1'b0, 1'b0);
    rst = 1'b0; rr_mode = 1'b1; req_in = 8'b1000_0001;
    cyc("mr_post_grant_7", 7, 1'b1, 1'b0);
    done_in = 1'b1;
    cyc("mr_release", -1, 1'b1, 1'b0);
    done_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
